bundle_irq_arbiter: RTL and testbench
=====================================

# bundle_irq_arbiter

Round-robin event arbiter for the 3-bit interrupt-style bundle that the bundle-bridge nexus fans out to consumers. Detects rising edges on each bundle bit and latches them as pending events. Presents one event at a time to a single consumer over a valid/ready port, and counts events lost to overlap. Sits between the nexus output and the consumer tile/controller, which no longer samples raw levels.

## Interface
- `N`, default 3: number of bundle bits (sources); legal range 2..8.
- `IDW`, default `max(1, $clog2(N))`: width of the source id.
- `MASK_RESET`, default 0: reset value of the mask register.
- `clock` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `auto_in` input N: level sources from the nexus, one bit per source.
- `out_valid` output 1: an event is presented.
- `out_id` output IDW: index of the presented source.
- `out_ready` input 1: consumer accepts the event.
- `cfg_mask_we` input 1: write strobe for the mask.
- `cfg_mask_wdata` input N: new mask; bit=1 makes a source ineligible.
- `mask` output N: current mask register.
- `pending` output N: current pending register.
- `drop_count` output 8: saturating count of lost events.

## Operation
- Edge detect: `edge = src & ~prev`, where `prev` is registered `src`. `src` is `auto_in`, or its synchronized copy (see Configuration).
- Pending update: `pending_next = (pending & ~clr) | edge`.
  - `clr` is a one-hot of `out_id` when `out_valid & out_ready`; otherwise 0.
- Drop: when `edge & pending & ~clr` is non-zero, `drop_count` increments by 1, regardless of how many bits are set. It saturates at 255 and never wraps.
- Eligibility: `elig = pending & ~clr & ~mask`.
- Round-robin pointer `ptr` (IDW bits, range 0..N-1):
  - Selection is the first set bit of `elig` scanning `ptr`, `ptr+1`, …, wrapping modulo N.
  - On handshake, `ptr <= (out_id + 1) mod N`.
- Output register `{out_valid, out_id}` is loaded when `!out_valid | out_ready`:
  - If `elig != 0`: `out_valid <= 1`, `out_id <= selected index`.
  - Otherwise: `out_valid <= 0`.
  - Back-to-back grants are therefore possible every cycle.
- Stability: while `out_valid & !out_ready`, `out_id` holds. This holds even if the mask is written to cover it; there is no revoke.
- Mask write: `mask <= cfg_mask_wdata` on `cfg_mask_we`. The new mask affects selection from the next cycle. Masked sources still set `pending` and still count drops.
- Same-cycle edge and grant on one source: `pending` stays 1 (new event), with no drop.
- Reset values:
  - `out_valid` 0, `out_id` 0, `pending` 0, `prev` 0, `ptr` 0, `drop_count` 0, `mask` = `MASK_RESET`.
  - Because `prev` resets to 0, a source already high at reset release counts as one event.
- Reset mid-operation: all state clears immediately (asynchronous). Any presented event is lost and is not counted as a drop.

## Timing
- Latency without sync, from `auto_in` rising in cycle 0:
  - `pending` set in cycle 1.
  - `out_valid` high in cycle 2, if the output is idle and the source is unmasked.
- Latency with `BUNDLE_IRQ_ARB_SYNC_EN`: 2 extra cycles, so `out_valid` in cycle 4.
- Handshake in cycle t: `pending[id]` clears and `ptr` advances at the end of t. The next eligible event is presented in cycle t+1.
- Throughput: 1 event per cycle when `out_ready` is held high.
- `mask` and `drop_count` update one cycle after the causing event.

## Configuration
- `BUNDLE_IRQ_ARB_SYNC_EN`:
  - Defined: `src` is `auto_in` through a 2-flop synchronizer per bit (reset to 0). Use this for sources from another clock domain.
  - Undefined: `src = auto_in` directly, with no added latency.
  - All other behaviour is identical.

## Test plan
- Single event: reset, N=3, pulse `auto_in`=3'b010 for 1 cycle, `out_ready`=1 → `out_valid` in cycle 2 with `out_id`=1; `pending` back to 0 in cycle 3; `drop_count`=0.
- Round-robin: `auto_in` 3'b000→3'b111 in one cycle, `out_ready`=1 → ids 0,1,2 on consecutive cycles; then a second 3'b111 burst starting with `ptr`=0 → 0,1,2 again.
- Backpressure and drop: `out_ready`=0; pulse bit 0 twice (0→1→0→1) → `out_id`=0 held stable, `drop_count`=1; after 300 such overlaps `drop_count`=255.
- Mask: write `mask`=3'b001, then pulse 3'b001 → no `out_valid`, `pending`=3'b001; clear `mask` → `out_valid` with `out_id`=0 two cycles after the write.
- Edge coinciding with grant: bit 2 presented; `out_ready`=1 in the same cycle as a new rising edge on bit 2 → `drop_count` unchanged, bit 2 presented again on the next cycle.
- Reset mid-burst: assert `reset` while `out_valid`=1 and `pending`=3'b110 → all outputs 0 asynchronously; with `auto_in` held 3'b100 through release → `out_id`=2 presented 2 cycles after release (4 with SYNC_EN).

Source files
------------

// File: rtl/bundle_irq_arbiter.sv
// Round-robin rising-edge event arbiter for the nexus interrupt bundle.
// Optional BUNDLE_IRQ_ARB_SYNC_EN adds a 2-flop input synchronizer per bit.
module bundle_irq_arbiter #(
    parameter int            N          = 3,
    parameter int            IDW        = ($clog2(N) > 1) ? $clog2(N) : 1,
    parameter logic [N-1:0]  MASK_RESET = '0
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   auto_in,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    input  logic           out_ready,
    input  logic           cfg_mask_we,
    input  logic [N-1:0]   cfg_mask_wdata,
    output logic [N-1:0]   mask,
    output logic [N-1:0]   pending,
    output logic [7:0]     drop_count
);

    logic [N-1:0]   w_src;
    logic [N-1:0]   r_prev;
    logic [N-1:0]   r_pending;
    logic [N-1:0]   r_mask;
    logic [7:0]     r_drop;
    logic [IDW-1:0] r_ptr;
    logic           r_out_valid;
    logic [IDW-1:0] r_out_id;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_clr;
    logic [N-1:0]   w_elig;
    logic           w_fire;
    logic           w_load;
    logic [IDW-1:0] w_sel;
    logic [IDW-1:0] w_ptr_nxt;

`ifdef BUNDLE_IRQ_ARB_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= auto_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = auto_in;
`endif

    assign w_edge = w_src & ~r_prev;
    assign w_fire = r_out_valid & out_ready;
    assign w_load = ~r_out_valid | out_ready;
    assign w_elig = r_pending & ~w_clr & ~r_mask;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++)
            w_clr[i] = w_fire && (int'(r_out_id) == i);
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            for (int j = 0; j < N; j++)
                if (j == idx && w_elig[j]) w_sel = IDW'(j);
        end
    end

    always_comb begin
        int t;
        t = int'(r_out_id) + 1;
        if (t >= N) t = 0;
        w_ptr_nxt = IDW'(t);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prev      <= '0;
            r_pending   <= '0;
            r_mask      <= MASK_RESET;
            r_drop      <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= '0;
        end else begin
            r_prev    <= w_src;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (cfg_mask_we)
                r_mask <= cfg_mask_wdata;
            if (|(w_edge & r_pending & ~w_clr) && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
            if (w_fire)
                r_ptr <= w_ptr_nxt;
            if (w_load) begin
                r_out_valid <= |w_elig;
                if (|w_elig)
                    r_out_id <= w_sel;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_id     = r_out_id;
    assign mask       = r_mask;
    assign pending    = r_pending;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_bundle_irq_arbiter.sv
// Directed self-checking bench for bundle_irq_arbiter (N=3, default build).
module tb_bundle_irq_arbiter;

    logic       clock;
    logic       reset;
    logic [2:0] auto_in;
    logic       out_valid;
    logic [1:0] out_id;
    logic       out_ready;
    logic       cfg_mask_we;
    logic [2:0] cfg_mask_wdata;
    logic [2:0] mask;
    logic [2:0] pending;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    bundle_irq_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .auto_in        (auto_in),
        .out_valid      (out_valid),
        .out_id         (out_id),
        .out_ready      (out_ready),
        .cfg_mask_we    (cfg_mask_we),
        .cfg_mask_wdata (cfg_mask_wdata),
        .mask           (mask),
        .pending        (pending),
        .drop_count     (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        auto_in        = '0;
        out_ready      = 1'b0;
        cfg_mask_we    = 1'b0;
        cfg_mask_wdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", out_id); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b want 000", pending); end
        checks++; if (mask !== 3'b000) begin errors++; $display("FAIL reset_mask: got %b want 000", mask); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        auto_in   = 3'b010;
        tick();
        auto_in = 3'b000;
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL single_pend_c1: got %b want 010", pending); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c1: got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1) begin errors++; $display("FAIL single_grant_c2: got v=%0b id=%0d want v=1 id=1", out_valid, out_id); end
        tick();
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_pend_c3: got %b want 000", pending); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_c3: got %0b want 0", out_valid); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL single_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_round_robin();
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            auto_in = 3'b111;
            tick();
            auto_in = 3'b000;
            checks++; if (pending !== 3'b111) begin errors++; $display("FAIL rr_pend b%0d: got %b want 111", b, pending); end
            for (int k = 0; k < 3; k++) begin
                tick();
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'(k)) begin
                    errors++;
                    $display("FAIL rr_grant b%0d k%0d: got v=%0b id=%0d want v=1 id=%0d", b, k, out_valid, out_id, k);
                end
            end
            tick();
            checks++; if (out_valid !== 1'b0 || pending !== 3'b000) begin errors++; $display("FAIL rr_idle b%0d: got v=%0b pend=%b want v=0 pend=000", b, out_valid, pending); end
        end
    endtask

    task automatic test_backpressure_drop();
        do_reset();
        out_ready = 1'b0;
        auto_in   = 3'b001;
        tick();
        auto_in = 3'b000;
        tick();
        auto_in = 3'b001;
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL bp_grant: got v=%0b id=%0d want v=1 id=0", out_valid, out_id); end
        tick();
        checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL bp_drop1: got %0d want 1", drop_count); end
        for (int i = 0; i < 299; i++) begin
            auto_in = 3'b000;
            tick();
            auto_in = 3'b001;
            tick();
        end
        checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL bp_drop_sat: got %0d want 255", drop_count); end
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL bp_hold: got v=%0b id=%0d want v=1 id=0", out_valid, out_id); end
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL bp_pend: got %b want 001", pending); end
    endtask

    task automatic test_mask();
        do_reset();
        out_ready      = 1'b1;
        cfg_mask_we    = 1'b1;
        cfg_mask_wdata = 3'b001;
        tick();
        cfg_mask_we = 1'b0;
        checks++; if (mask !== 3'b001) begin errors++; $display("FAIL mask_write: got %b want 001", mask); end
        auto_in = 3'b001;
        tick();
        auto_in = 3'b000;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mask_block: got v=%0b want 0", out_valid); end
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL mask_pend: got %b want 001", pending); end
        cfg_mask_we    = 1'b1;
        cfg_mask_wdata = 3'b000;
        tick();
        cfg_mask_we = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mask_early: got v=%0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL mask_release: got v=%0b id=%0d want v=1 id=0", out_valid, out_id); end
    endtask

    task automatic test_edge_with_grant();
        do_reset();
        out_ready = 1'b0;
        auto_in   = 3'b100;
        tick();
        auto_in = 3'b000;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin errors++; $display("FAIL ewg_grant: got v=%0b id=%0d want v=1 id=2", out_valid, out_id); end
        out_ready = 1'b1;
        auto_in   = 3'b100;
        tick();
        auto_in = 3'b000;
        checks++; if (pending !== 3'b100) begin errors++; $display("FAIL ewg_pend: got %b want 100", pending); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL ewg_drop: got %0d want 0", drop_count); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin errors++; $display("FAIL ewg_regrant: got v=%0b id=%0d want v=1 id=2", out_valid, out_id); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        out_ready = 1'b0;
        auto_in   = 3'b110;
        tick();
        auto_in = 3'b100;
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd1 || pending !== 3'b110) begin errors++; $display("FAIL rmb_pre: got v=%0b id=%0d pend=%b want v=1 id=1 pend=110", out_valid, out_id, pending); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_id !== 2'd0) begin errors++; $display("FAIL rmb_async_out: got v=%0b id=%0d want v=0 id=0", out_valid, out_id); end
        checks++; if (pending !== 3'b000 || drop_count !== 8'd0) begin errors++; $display("FAIL rmb_async_state: got pend=%b drop=%0d want pend=000 drop=0", pending, drop_count); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if (pending !== 3'b100 || out_valid !== 1'b0) begin errors++; $display("FAIL rmb_c1: got pend=%b v=%0b want pend=100 v=0", pending, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_id !== 2'd2) begin errors++; $display("FAIL rmb_c2: got v=%0b id=%0d want v=1 id=2", out_valid, out_id); end
    endtask

    initial begin
        reset          = 1'b1;
        auto_in        = '0;
        out_ready      = 1'b0;
        cfg_mask_we    = 1'b0;
        cfg_mask_wdata = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure_drop();
        test_mask();
        test_edge_with_grant();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
